// File: rtl/gx4000_sprite_linebuf_if.sv
// Host attribute-write bus and pattern-RAM read bus of the GX4000 sprite line buffer.
// The slave modport is the sprite engine; the master modport is the CPU/ASIC side.
interface gx4000_sprite_linebuf_if #(
  parameter int NUM_SPR = 16,
  parameter int RAM_AW  = 14
);
  localparam int IW = $clog2(NUM_SPR);

  logic              reg_wr;
  logic [IW-1:0]     reg_idx;
  logic [2:0]        reg_field;
  logic [7:0]        reg_data;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_rd;
  logic [7:0]        ram_q;

  modport master (
    output reg_wr, reg_idx, reg_field, reg_data, ram_q,
    input  ram_addr, ram_rd
  );

  modport slave (
    input  reg_wr, reg_idx, reg_field, reg_data, ram_q,
    output ram_addr, ram_rd
  );
endinterface

// File: rtl/gx4000_sprite_linebuf.sv
// Double-buffered GX4000 sprite engine: renders the next line into a back buffer from
// pattern RAM while the front buffer streams pen/id to the mixer with read-then-clear.
module gx4000_sprite_linebuf #(
  parameter int                NUM_SPR  = 16,
  parameter int                SPR_W    = 16,
  parameter int                SPR_H    = 16,
  parameter int                LINE_W   = 384,
  parameter int                RAM_AW   = 14,
  parameter logic [RAM_AW-1:0] PAT_BASE = '0
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       line_start,
  input  logic [8:0]                 next_vpos,
  input  logic [8:0]                 hpos,
  input  logic                       de,
  gx4000_sprite_linebuf_if.slave     bus,
  output logic                       pix_valid,
  output logic [3:0]                 pix_pen,
  output logic [$clog2(NUM_SPR)-1:0] pix_id,
  output logic [NUM_SPR-1:0]         collision,
  input  logic                       coll_clr,
  output logic                       busy,
  output logic                       overrun
);
  localparam int IW = $clog2(NUM_SPR);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int SW = CW + 3;
  localparam int AW = $clog2(LINE_W);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_EVAL, S_FETCH} state_t;

  typedef struct packed {
    logic [3:0]    pen;
    logic [IW-1:0] id;
  } entry_t;

  logic [8:0] spr_x [NUM_SPR];
  logic [8:0] spr_y [NUM_SPR];
  logic [1:0] mag_x [NUM_SPR];
  logic [1:0] mag_y [NUM_SPR];

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [IW-1:0]     idx;
  logic [8:0]        vpos_q;
  logic [RW-1:0]     row_q;
  logic [1:0]        xlog_q;
  logic [SW-1:0]     slot;
  logic              ram_rd_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic              buf_sel;

  // s1: read issued to RAM this cycle; s2: RAM data present, write to back buffer.
  logic          s1_v, s1_first, s2_v, s2_first;
  logic [9:0]    s1_pos, s2_pos;
  logic [IW-1:0] s1_id, s2_id;
  logic [3:0]    pen_hold;

  logic [9:0]    d_row, span;
  logic [1:0]    ylog;
  logic          hit;
  logic [SW-1:0] m_mask, last_slot;
  logic [CW-1:0] col;
  logic          first;

  entry_t        buf0 [LINE_W];
  entry_t        buf1 [LINE_W];
  entry_t        front_q, back_old, wr_entry;
  logic [3:0]    wr_pen;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_idx, hidx;
  logic [NUM_SPR-1:0] coll_set;
  logic [3:0]    unused_q;

  assign bus.ram_rd   = ram_rd_q;
  assign bus.ram_addr = ram_addr_q;
  assign unused_q     = bus.ram_q[7:4];
  assign busy         = (state != S_IDLE) || s1_v || s2_v;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        spr_x[i] <= '0;
        spr_y[i] <= '0;
        mag_x[i] <= '0;
        mag_y[i] <= '0;
      end
    end else if (bus.reg_wr) begin
      case (bus.reg_field)
        3'd0: spr_x[bus.reg_idx][7:0] <= bus.reg_data;
        3'd1: spr_x[bus.reg_idx][8]   <= bus.reg_data[0];
        3'd2: spr_y[bus.reg_idx][7:0] <= bus.reg_data;
        3'd3: spr_y[bus.reg_idx][8]   <= bus.reg_data[0];
        3'd4: begin
          mag_x[bus.reg_idx] <= bus.reg_data[3:2];
          mag_y[bus.reg_idx] <= bus.reg_data[1:0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    ylog      = mag_y[idx] - 2'd1;
    d_row     = {1'b0, vpos_q} - {1'b0, spr_y[idx]};
    span      = 10'(SPR_H) << ylog;
    hit       = (mag_x[idx] != 2'd0) && (mag_y[idx] != 2'd0) && (d_row < span);
    m_mask    = (SW'(1) << xlog_q) - SW'(1);
    last_slot = (SW'(SPR_W) << xlog_q) - SW'(1);
    col       = CW'(slot >> xlog_q);
    first     = (slot & m_mask) == '0;
  end

  // NOTE: sequential state uses non-blocking assignments only; later lines override defaults.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      idx        <= '0;
      vpos_q     <= '0;
      row_q      <= '0;
      xlog_q     <= '0;
      slot       <= '0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      buf_sel    <= 1'b0;
      overrun    <= 1'b0;
      s1_v       <= 1'b0;
      s1_first   <= 1'b0;
      s1_pos     <= '0;
      s1_id      <= '0;
      s2_v       <= 1'b0;
      s2_first   <= 1'b0;
      s2_pos     <= '0;
      s2_id      <= '0;
      pen_hold   <= '0;
    end else begin
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_pos   <= s1_pos;
      s2_id    <= s1_id;
      s1_v     <= 1'b0;
      ram_rd_q <= 1'b0;
      if (s2_v) pen_hold <= wr_pen;

      if (line_start && state != S_CLEAR) begin
        // In-flight reads belong to the line being abandoned.
        if (busy) overrun <= 1'b1;
        buf_sel <= ~buf_sel;
        vpos_q  <= next_vpos;
        idx     <= IW'(NUM_SPR - 1);
        state   <= S_EVAL;
        s2_v    <= 1'b0;
      end else begin
        case (state)
          S_CLEAR: begin
            if (clr_cnt == AW'(LINE_W - 1)) state <= S_IDLE;
            else clr_cnt <= clr_cnt + AW'(1);
          end
          S_EVAL: begin
            if (hit) begin
              state  <= S_FETCH;
              row_q  <= RW'(d_row >> ylog);
              xlog_q <= mag_x[idx] - 2'd1;
              slot   <= '0;
            end else if (idx == '0) begin
              state <= S_IDLE;
            end else begin
              idx <= idx - IW'(1);
            end
          end
          S_FETCH: begin
            s1_v       <= 1'b1;
            s1_first   <= first;
            s1_pos     <= {1'b0, spr_x[idx]} + 10'(slot);
            s1_id      <= idx;
            ram_rd_q   <= first;
            ram_addr_q <= PAT_BASE + RAM_AW'({idx, row_q, col});
            if (slot == last_slot) begin
              if (idx == '0) begin
                state <= S_IDLE;
              end else begin
                idx   <= idx - IW'(1);
                state <= S_EVAL;
              end
            end else begin
              slot <= slot + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr_pen   = s2_first ? bus.ram_q[3:0] : pen_hold;
  assign wr_idx   = AW'(s2_pos);
  assign hidx     = AW'(hpos);
  assign wr_en    = s2_v && (wr_pen != 4'd0) && (int'(s2_pos) < LINE_W);
  assign rd_en    = de && (int'(hpos) < LINE_W) && (state != S_CLEAR);
  assign wr_entry = '{pen: wr_pen, id: s2_id};
  assign front_q  = buf_sel ? buf1[hidx] : buf0[hidx];
  assign back_old = buf_sel ? buf0[wr_idx] : buf1[wr_idx];

  // NOTE: the line buffers carry no reset; the CLEAR sweep zeroes them so they can map onto RAM.
  always_ff @(posedge clk_sys) begin
    if (state == S_CLEAR) begin
      buf0[clr_cnt] <= '0;
      buf1[clr_cnt] <= '0;
    end else if (buf_sel) begin
      if (wr_en) buf0[wr_idx] <= wr_entry;
      if (rd_en) buf1[hidx]   <= '0;
    end else begin
      if (wr_en) buf1[wr_idx] <= wr_entry;
      if (rd_en) buf0[hidx]   <= '0;
    end
  end

  always_comb begin
    coll_set = '0;
    if (wr_en && back_old.pen != 4'd0) begin
      coll_set[s2_id]       = 1'b1;
      coll_set[back_old.id] = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      collision <= '0;
      pix_valid <= 1'b0;
      pix_pen   <= '0;
      pix_id    <= '0;
    end else begin
      collision <= (coll_clr ? '0 : collision) | coll_set;
      if (rd_en) begin
        pix_valid <= front_q.pen != 4'd0;
        pix_pen   <= front_q.pen;
        pix_id    <= front_q.id;
      end else begin
        pix_valid <= 1'b0;
        pix_pen   <= '0;
        pix_id    <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gx4000_sprite_linebuf.sv
// Randomised bench for gx4000_sprite_linebuf against a per-line array model of sprite
// rendering, priority, magnification, clipping and collision.
module tb_gx4000_sprite_linebuf;
  localparam int NUM_SPR = 16;
  localparam int SPR_W   = 16;
  localparam int SPR_H   = 16;
  localparam int LINE_W  = 384;
  localparam int RAM_AW  = 14;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [8:0]  next_vpos = '0;
  logic [8:0]  hpos = '0;
  logic        de = 1'b0;
  logic        coll_clr = 1'b0;
  logic        pix_valid;
  logic [3:0]  pix_pen;
  logic [3:0]  pix_id;
  logic [15:0] collision;
  logic        busy, overrun;

  gx4000_sprite_linebuf_if #(.NUM_SPR(NUM_SPR), .RAM_AW(RAM_AW)) bus ();

  gx4000_sprite_linebuf #(
    .NUM_SPR(NUM_SPR), .SPR_W(SPR_W), .SPR_H(SPR_H), .LINE_W(LINE_W),
    .RAM_AW(RAM_AW), .PAT_BASE('0)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .line_start(line_start), .next_vpos(next_vpos),
    .hpos(hpos), .de(de), .bus(bus), .pix_valid(pix_valid), .pix_pen(pix_pen),
    .pix_id(pix_id), .collision(collision), .coll_clr(coll_clr), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk_sys = ~clk_sys;

  logic [7:0] pat [1 << RAM_AW];

  // Pattern RAM: data one cycle after a read strobe, noise otherwise.
  always @(posedge clk_sys)
    bus.ram_q <= bus.ram_rd ? pat[bus.ram_addr] : 8'($urandom);

  int n_checks = 0;
  int n_fail   = 0;

  int mx [NUM_SPR], my [NUM_SPR], mmx [NUM_SPR], mmy [NUM_SPR];
  int b_pen [LINE_W], b_id [LINE_W], f_pen [LINE_W], f_id [LINE_W];
  int cap_v [512], cap_pen [512], cap_id [512];
  logic [31:0] mcoll;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_SPR; n++) begin
      mx[n] = 0; my[n] = 0; mmx[n] = 0; mmy[n] = 0;
    end
    for (int p = 0; p < LINE_W; p++) begin
      b_pen[p] = 0; b_id[p] = 0; f_pen[p] = 0; f_id[p] = 0;
    end
    mcoll = 0;
  endtask

  task automatic model_render(input int v);
    int ylog, xm, d, row, pen, p;
    for (int q = 0; q < LINE_W; q++) begin
      b_pen[q] = 0; b_id[q] = 0;
    end
    for (int n = NUM_SPR - 1; n >= 0; n--) begin
      if (mmx[n] != 0 && mmy[n] != 0) begin
        ylog = mmy[n] - 1;
        xm   = 1 << (mmx[n] - 1);
        d    = v - my[n];
        if (d >= 0 && d < (SPR_H << ylog)) begin
          row = d >> ylog;
          for (int c = 0; c < SPR_W; c++) begin
            pen = int'(pat[n * SPR_W * SPR_H + row * SPR_W + c]) & 15;
            for (int k = 0; k < xm; k++) begin
              p = mx[n] + c * xm + k;
              if (pen != 0 && p < LINE_W) begin
                if (b_pen[p] != 0) mcoll = mcoll | (32'd1 << n) | (32'd1 << b_id[p]);
                b_pen[p] = pen;
                b_id[p]  = n;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic wr_attr(input int n, input int f, input int d);
    @(negedge clk_sys);
    bus.reg_wr    = 1'b1;
    bus.reg_idx   = 4'(n);
    bus.reg_field = 3'(f);
    bus.reg_data  = 8'(d);
    @(negedge clk_sys);
    bus.reg_wr = 1'b0;
  endtask

  task automatic set_sprite(input int n, input int x, input int y, input int mag);
    wr_attr(n, 0, x & 255);
    wr_attr(n, 1, x >> 8);
    wr_attr(n, 2, y & 255);
    wr_attr(n, 3, y >> 8);
    wr_attr(n, 4, mag);
    mx[n] = x; my[n] = y; mmx[n] = (mag >> 2) & 3; mmy[n] = mag & 3;
  endtask

  task automatic pulse_line(input int v);
    @(negedge clk_sys);
    next_vpos  = 9'(v);
    line_start = 1'b1;
    @(negedge clk_sys);
    line_start = 1'b0;
  endtask

  task automatic pulse_coll_clr();
    @(negedge clk_sys);
    coll_clr = 1'b1;
    @(negedge clk_sys);
    coll_clr = 1'b0;
    mcoll = 0;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clk_sys);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic sample(input int p);
    logic [31:0] exp;
    cap_v[p]   = int'(pix_valid);
    cap_pen[p] = int'(pix_pen);
    cap_id[p]  = int'(pix_id);
    exp = 0;
    if (p < LINE_W && f_pen[p] != 0) exp = {23'd0, 1'b1, 4'(f_pen[p]), 4'(f_id[p])};
    check($sformatf("pix@%0d", p), {23'd0, pix_valid, pix_pen, pix_id}, exp);
  endtask

  // Scan slightly past the buffer end with de high, then check that de low blanks.
  task automatic scan_line();
    for (int h = 0; h <= LINE_W + 2; h++) begin
      @(negedge clk_sys);
      if (h > 0) sample(h - 1);
      hpos = 9'(h);
      de   = 1'b1;
    end
    @(negedge clk_sys);
    sample(LINE_W + 2);
    de   = 1'b0;
    hpos = '0;
    @(negedge clk_sys);
    check("pix_de0", {23'd0, pix_valid, pix_pen, pix_id}, 32'd0);
  endtask

  task automatic do_line(input int v);
    pulse_line(v);
    for (int p = 0; p < LINE_W; p++) begin
      f_pen[p] = b_pen[p]; f_id[p] = b_id[p];
    end
    model_render(v);
    scan_line();
    wait_idle(4000, "render");
    check("collision", 32'(collision), mcoll);
    check("overrun", 32'(overrun), 32'd0);
  endtask

  task automatic disable_all();
    for (int n = 0; n < NUM_SPR; n++)
      if (mmx[n] != 0 || mmy[n] != 0) set_sprite(n, 0, 0, 0);
  endtask

  initial begin
    int v, wait_n;
    for (int i = 0; i < (1 << RAM_AW); i++) pat[i] = 8'($urandom);
    bus.reg_wr = 1'b0; bus.reg_idx = '0; bus.reg_field = '0; bus.reg_data = '0;
    model_reset();

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    #1;
    check("rst_busy_clear", 32'(busy), 32'd1);
    check("rst_pix", {23'd0, pix_valid, pix_pen, pix_id}, 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
    wait_idle(1000, "clear");

    // Sprite 0, x1/x1, row 0 pens 1..15 then transparent.
    for (int c = 0; c < SPR_W; c++) pat[c] = 8'((c < 15) ? c + 1 : 0);
    set_sprite(0, 10, 20, 4'b0101);
    do_line(20);
    do_line(21);
    check("t1_h9", 32'(cap_v[9]), 32'd0);
    check("t1_h10", 32'(cap_pen[10]), 32'd1);
    check("t1_h24", 32'(cap_pen[24]), 32'd15);
    check("t1_h25", 32'(cap_v[25]), 32'd0);

    // Sprite 3, x4 horizontally and x2 vertically.
    disable_all();
    pat[3 * 256 + 0]  = 8'h05;
    pat[3 * 256 + 16] = 8'h09;
    set_sprite(3, 0, 100, 4'b1110);
    do_line(100);
    do_line(101);
    for (int h = 0; h < 4; h++)
      check($sformatf("t2_row0_h%0d", h), {24'd0, 4'(cap_pen[h]), 4'(cap_id[h])}, 32'h53);
    do_line(102);
    check("t2_y2_repeat", 32'(cap_pen[0]), 32'd5);
    do_line(103);
    check("t2_row1", 32'(cap_pen[0]), 32'd9);

    // Sprites 1 and 2 overlap; sprite 1 wins, both flag.
    disable_all();
    pulse_coll_clr();
    pat[1 * 256] = 8'h07;
    pat[2 * 256] = 8'h07;
    set_sprite(1, 50, 150, 4'b0101);
    set_sprite(2, 50, 150, 4'b0101);
    do_line(150);
    check("t3_coll", 32'(collision), 32'h6);
    pulse_coll_clr();
    check("t3_coll_clr", 32'(collision), 32'h0);
    do_line(150);
    check("t3_coll_again", 32'(collision), 32'h6);
    check("t3_id50", {24'd0, 4'(cap_pen[50]), 4'(cap_id[50])}, 32'h71);

    // Right-edge clipping without wrap.
    disable_all();
    pulse_coll_clr();
    for (int c = 0; c < SPR_W; c++) pat[c] = 8'((c % 15) + 1);
    set_sprite(0, 380, 200, 4'b0101);
    do_line(200);
    do_line(201);
    for (int h = 380; h < 384; h++)
      check($sformatf("t4_h%0d", h), {28'd0, 4'(cap_pen[h])}, 32'(h - 379));
    check("t4_nowrap", 32'(cap_v[0]), 32'd0);
    check("t4_past_end", 32'(cap_v[384]), 32'd0);

    // Random attributes and patterns.
    pulse_coll_clr();
    for (int l = 0; l < 8; l++) begin
      v = $urandom_range(64, 300);
      for (int n = 0; n < NUM_SPR; n++)
        set_sprite(n, $urandom_range(0, 400), v - $urandom_range(0, 70), $urandom_range(0, 15));
      do_line(v);
    end
    do_line(0);

    // Overrun: every sprite hits at x4/x4 and the next line arrives early.
    for (int n = 0; n < NUM_SPR; n++) set_sprite(n, $urandom_range(0, 383), 250, 4'b1111);
    pulse_line(250);
    repeat (200) @(negedge clk_sys);
    pulse_line(251);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    repeat (5) @(negedge clk_sys);
    check("t5_busy_restart", 32'(busy), 32'd1);

    // Reset while fetching.
    wait_n = 0;
    while (!bus.ram_rd && wait_n < 50) begin
      @(negedge clk_sys);
      wait_n++;
    end
    check("t6_in_fetch", 32'(bus.ram_rd), 32'd1);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    check("t6_ram_rd", 32'(bus.ram_rd), 32'd0);
    check("t6_collision", 32'(collision), 32'd0);
    check("t6_overrun", 32'(overrun), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    model_reset();
    wait_idle(1000, "t6_clear");
    do_line(250);
    do_line(251);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
